// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg: shared sizes, reset address and sequencer state type
package program_sequencer_pkg;
  localparam int DEF_PC_W = 8;
  localparam int DEF_CNT_W = 16;
  localparam logic [DEF_PC_W-1:0] DEF_RESET_ADDR = 8'h00;
  typedef enum logic [1:0] {BOOT, RUN, HALT, STEP} seq_state_t;
endpackage

// File: rtl/program_sequencer_if.sv
// program_sequencer_if: decoder/debug inputs and fetch/observation outputs of the sequencer
interface program_sequencer_if #(
  parameter int PC_W = 8,
  parameter int CNT_W = 16
);
  logic jmp;
  logic jmp_nz;
  logic [3:0] jmp_addr;
  logic dont_jmp;
  logic halt_req;
  logic step_req;
  logic resume;
  logic bp_en;
  logic [PC_W-1:0] bp_addr;
  logic [PC_W-1:0] pm_addr;
  logic [PC_W-1:0] pc;
  logic halted;
  logic [CNT_W-1:0] instr_count;
  logic [7:0] from_PS;
  modport master (
    output jmp, jmp_nz, jmp_addr, dont_jmp, halt_req, step_req, resume, bp_en, bp_addr,
    input pm_addr, pc, halted, instr_count, from_PS
  );
  modport slave (
    input jmp, jmp_nz, jmp_addr, dont_jmp, halt_req, step_req, resume, bp_en, bp_addr,
    output pm_addr, pc, halted, instr_count, from_PS
  );
endinterface

// File: rtl/program_sequencer_step_edge_detect.sv
// step_edge_detect: one-cycle pulse on each rising edge of a level input
module step_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic pulse_o
);
  logic d_q;
  // remember last cycle's level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) d_q <= 1'b0;
    else d_q <= d_i;
  end
  assign pulse_o = d_i & ~d_q;
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: PC/fetch-address generation with halt, single-step, breakpoint and fetch counter
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [PC_W-1:0] RESET_ADDR = DEF_RESET_ADDR
) (
  input logic clk,
  input logic reset_n,
  program_sequencer_if.slave bus
);
  seq_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pm_addr_d, adv_addr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic bp_mask_q, bp_mask_d;
  logic step_pulse, bp_hit, stop, adv;
  step_edge_detect u_step (
    .clk(clk),
    .reset_n(reset_n),
    .d_i(bus.step_req),
    .pulse_o(step_pulse)
  );
  assign bp_hit = bus.bp_en & (pc_q == bus.bp_addr) & ~bp_mask_q;
  assign stop = bus.halt_req | bp_hit;
  assign adv_addr = (bus.jmp | (bus.jmp_nz & ~bus.dont_jmp)) ? {pc_q[PC_W-1:4], bus.jmp_addr}
                                                              : pc_q + PC_W'(1);
  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q <= RESET_ADDR;
      cnt_q <= '0;
      bp_mask_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pm_addr_d;
      cnt_q <= cnt_d;
      bp_mask_q <= bp_mask_d;
    end
  end
  // next-state selection; a halting RUN cycle already uses HALT semantics
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: state_d = stop ? HALT : RUN;
      HALT: state_d = (bus.resume & ~bus.halt_req) ? RUN : step_pulse ? STEP : HALT;
      STEP: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end
  // fetch address, counter and breakpoint mask for this cycle
  always_comb begin
    adv = ((state_q == RUN) & ~stop) | (state_q == STEP);
    pm_addr_d = (state_q == BOOT) ? RESET_ADDR : adv ? adv_addr : pc_q;
    cnt_d = (adv && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    bp_mask_d = (state_q == HALT) & (state_d != HALT);
  end
  assign bus.pm_addr = pm_addr_d;
  assign bus.pc = pc_q;
  assign bus.halted = (state_q == HALT);
  assign bus.instr_count = cnt_q;
  assign bus.from_PS = 8'(pc_q);
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Fetch-side stage directly upstream of the instruction decoder. It holds the program counter and drives pm_addr to the synchronous program memory, whose output becomes the decoder's next_instr. It consumes the decoder's jmp, jmp_nz and ir_nibble outputs, plus the ALU zero-derived dont_jmp flag. It adds debug control: halt, single-step, one hardware breakpoint and a retired-fetch counter.

Parameters:
PC_W, 8, program counter and pm_addr width
CNT_W, 16, width of fetch counter
RESET_ADDR, 8'h00, address driven during BOOT

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
jmp  input  1  unconditional jump, from decoder
jmp_nz  input  1  conditional jump, from decoder
jmp_addr  input  4  jump target low nibble, from decoder ir_nibble
dont_jmp  input  1  ALU zero flag; 1 suppresses jmp_nz
halt_req  input  1  level request to enter HALT
step_req  input  1  single-step request; rising edge sensitive
resume  input  1  level request to leave HALT
bp_en  input  1  breakpoint enable
bp_addr  input  PC_W  breakpoint address
pm_addr  output  PC_W  next fetch address (combinational)
pc  output  PC_W  registered current address
halted  output  1  1 while state is HALT
instr_count  output  CNT_W  saturating count of advancing cycles
from_PS  output  8  debug/exam observation bus

Behaviour:
- Reset (reset_n=0, asynchronous): state=BOOT, pc=RESET_ADDR, instr_count=0, step edge register=0. Outputs under reset: pm_addr=RESET_ADDR, halted=0.
- Shared package enum seq_state_t contains BOOT, RUN, HALT and STEP.
- Advance address adv_addr:
  - jmp=1 -> {pc[7:4], jmp_addr}.
  - else jmp_nz=1 and dont_jmp=0 -> {pc[7:4], jmp_addr}.
  - else pc+1. The +1 wraps 8'hFF->8'h00 with no flag.
  - jmp and jmp_nz both 1: jmp wins. The result is the same address.
- pm_addr by state:
  - BOOT: RESET_ADDR.
  - RUN or STEP: adv_addr.
  - HALT: pc (re-fetch, no advance).
- pc <= pm_addr every cycle. It is therefore constant in HALT.
- step_pulse = step_req & ~step_req_q. step_req_q is registered every cycle.
- bp_hit = bp_en & (pc == bp_addr) & ~bp_mask. bp_mask is a register, set to 1 on the cycle after entering RUN or STEP from HALT, and 0 otherwise.
- Transitions (priority top-down):
  - BOOT: always -> RUN after 1 cycle.
  - RUN: halt_req or bp_hit -> HALT. The pm_addr of that same cycle is already pc, so the breakpoint instruction is not advanced past. Else stay RUN.
  - HALT:
    - resume=1 and halt_req=0 -> RUN.
    - else step_pulse -> STEP.
    - else stay HALT. resume together with halt_req stays HALT.
  - STEP: always -> HALT after exactly one advancing cycle. Breakpoint is ignored in STEP.
- RUN-cycle decision: the next state and pm_addr for a halting RUN cycle use HALT semantics combinationally. HALT is entered with pc frozen at the current value.
- instr_count increments on every cycle whose pm_addr came from adv_addr (RUN not halting, or STEP). It saturates at all-ones.
- halted=1 iff state==HALT.
- Downstream register enables must be gated with ~halted; that gating is outside this block.
- from_PS = pc. Exam hooks override this assignment only.
- Reset mid-STEP or mid-HALT returns to BOOT immediately, asynchronously.

Decomposition:
- Package defs gains seq_state_t and the localparam RESET_ADDR default.
- One sub-module, step_edge_detect: registered rising-edge detector, async active-low reset. The rest stays flat.

Test Plan:
- Reset release, no jumps: pm_addr 00 in BOOT, then 01,02,03 on successive cycles; instr_count=3 after 3 RUN cycles.
- pc=8'h37, jmp=1, jmp_addr=4'hA -> pm_addr=8'h3A same cycle; with jmp_nz=1, dont_jmp=1 -> pm_addr=8'h38.
- Wrap: pc=8'hFF, no jump -> pm_addr=8'h00, pc=00 next cycle.
- bp_en=1, bp_addr=8'h05 -> halted=1 with pc=05 held ≥10 cycles, instr_count frozen. Then resume pulse -> pc 06,07 (no re-trigger at 05).
- In HALT at pc=8'h10, step_req held high 5 cycles -> exactly one advance to 8'h11, then halted=1 again; a second rising edge -> 8'h12.
- Reset asserted mid-STEP -> pc=00, halted=0 and instr_count=0 immediately, without a clock edge.
